// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and types for the RV32I pipeline:
//                data/register-index widths, write-back control bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = $clog2(NREG);

   // Bit positions inside the 2-bit write-back control word
   localparam int CRT_WB_REG_WRITE  = 1;
   localparam int CRT_WB_MEM_TO_REG = 0;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] xlen_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_if
//  Description : MEM/WB write-back bundle, decode read ports and forwarding
//                outputs of the write-back stage. The master side is the
//                pipeline (MEM/WB register + decode), the slave side is
//                wb_regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if;
   import riscv_pkg::*;

   logic [1:0]  CRT_WB_IN;
   xlen_t       READ_DATA_IN;
   xlen_t       ALU_RESULT_IN;
   reg_addr_t   RD_IN;
   reg_addr_t   RS1_ADDR;
   reg_addr_t   RS2_ADDR;
   xlen_t       RS1_DATA;
   xlen_t       RS2_DATA;
   xlen_t       WB_DATA;
   reg_addr_t   WB_RD;
   logic        WB_WE;
   logic [31:0] WB_COUNT;

   modport master (
      output CRT_WB_IN, READ_DATA_IN, ALU_RESULT_IN, RD_IN, RS1_ADDR, RS2_ADDR,
      input  RS1_DATA, RS2_DATA, WB_DATA, WB_RD, WB_WE, WB_COUNT
   );

   modport slave (
      input  CRT_WB_IN, READ_DATA_IN, ALU_RESULT_IN, RD_IN, RS1_ADDR, RS2_ADDR,
      output RS1_DATA, RS2_DATA, WB_DATA, WB_RD, WB_WE, WB_COUNT
   );

endinterface : wb_regfile_if
`default_nettype wire

// File: rtl/regfile_array.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_array
//  Description : Raw NREG x XLEN storage with two asynchronous read ports,
//                one synchronous write port and a synchronous clear. Knows
//                nothing about x0 or bypassing; the caller handles both.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_array #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  wire logic            clk,
   input  wire logic            i_clr,
   input  wire logic            i_we,
   input  wire logic [AW-1:0]   i_waddr,
   input  wire logic [XLEN-1:0] i_wdata,
   input  wire logic [AW-1:0]   i_raddr1,
   input  wire logic [AW-1:0]   i_raddr2,
   output logic      [XLEN-1:0] o_rdata1,
   output logic      [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_mem [NREG];

   // Clear wins over a write presented in the same cycle
   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];

endmodule : regfile_array
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : RV32I write-back stage plus architectural register file.
//                Selects load data or ALU result, commits it (x0 discarded),
//                serves two combinational read ports and counts commits.
//  Config      : WB_BYPASS_EN - when defined, a read of the register being
//                committed this cycle returns the write-back value directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   wb_regfile_if.slave bus
);
   import riscv_pkg::*;

   logic [XLEN-1:0] w_wb_data;
   logic [XLEN-1:0] w_arr_rs1;
   logic [XLEN-1:0] w_arr_rs2;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic            w_we;
   logic [31:0]     r_wb_count;

   // Write-back select; driven regardless of REG_WRITE so EX can forward it
   always_comb begin
      w_wb_data = bus.CRT_WB_IN[CRT_WB_MEM_TO_REG] ? bus.READ_DATA_IN
                                                   : bus.ALU_RESULT_IN;
   end

   // A commit needs REG_WRITE, a non-zero destination and no reset
   assign w_we = bus.CRT_WB_IN[CRT_WB_REG_WRITE] & (bus.RD_IN != '0) & ~rst;

   regfile_array #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_array (
      .clk      (clk),
      .i_clr    (rst),
      .i_we     (w_we),
      .i_waddr  (bus.RD_IN),
      .i_wdata  (w_wb_data),
      .i_raddr1 (bus.RS1_ADDR),
      .i_raddr2 (bus.RS2_ADDR),
      .o_rdata1 (w_arr_rs1),
      .o_rdata2 (w_arr_rs2)
   );

   // Read-port resolution: array value, optional same-cycle bypass, then
   // x0/reset masking last so it always has the final say
   always_comb begin
      w_rs1_data = w_arr_rs1;
      w_rs2_data = w_arr_rs2;
`ifdef WB_BYPASS_EN
      if (w_we && (bus.RS1_ADDR == bus.RD_IN)) begin
         w_rs1_data = w_wb_data;
      end
      if (w_we && (bus.RS2_ADDR == bus.RD_IN)) begin
         w_rs2_data = w_wb_data;
      end
`else
      // Without the bypass, decode sees pre-commit contents until the edge
`endif
      if (rst || (bus.RS1_ADDR == '0)) begin
         w_rs1_data = '0;
      end
      if (rst || (bus.RS2_ADDR == '0)) begin
         w_rs2_data = '0;
      end
   end

   // Commit counter; wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_count <= '0;
      end else if (w_we) begin
         r_wb_count <= r_wb_count + 32'd1;
      end
   end

   assign bus.WB_DATA  = w_wb_data;
   assign bus.WB_WE    = w_we;
   assign bus.WB_RD    = w_we ? bus.RD_IN : '0;
   assign bus.RS1_DATA = w_rs1_data;
   assign bus.RS2_DATA = w_rs2_data;
   assign bus.WB_COUNT = r_wb_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Self-checking bench for wb_regfile: directed vector table,
//                reset/wrap sequences and randomized traffic against an
//                array-based reference model. Honours WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
   import riscv_pkg::*;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_regfile_if bus_if ();

   wb_regfile #(.XLEN(32), .NREG(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   typedef struct {
      logic        rst;
      logic [1:0]  crt;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic [31:0] e_wb;
      logic        e_we;
      logic [4:0]  e_wbrd;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic r, logic [1:0] c, logic [31:0] rdat,
                               logic [31:0] a, logic [4:0] d, logic [4:0] s1,
                               logic [4:0] s2, logic [31:0] x1, logic [31:0] x2,
                               logic [31:0] xwb, logic xwe, logic [4:0] xrd,
                               logic [31:0] xcnt);
      vec_t v;
      v.rst = r;  v.crt = c;  v.rdata = rdat; v.alu = a; v.rd = d;
      v.rs1 = s1; v.rs2 = s2; v.e_rs1 = x1;   v.e_rs2 = x2; v.e_wb = xwb;
      v.e_we = xwe; v.e_wbrd = xrd; v.e_cnt = xcnt;
      return v;
   endfunction

   // Architectural rules: value selected by MEM_TO_REG, commit only for
   // REG_WRITE to a non-zero register outside reset
   function automatic vec_t model_expect(input vec_t v);
      vec_t        o;
      logic [31:0] wb;
      logic        we;
      o  = v;
      wb = v.crt[0] ? v.rdata : v.alu;
      we = v.crt[1] && (v.rd != 5'd0) && !v.rst;
      o.e_wb   = wb;
      o.e_we   = we;
      o.e_wbrd = we ? v.rd : 5'd0;
      o.e_cnt  = m_cnt;
      if (v.rst || v.rs1 == 5'd0)          o.e_rs1 = 32'd0;
      else if (BYP && we && v.rs1 == v.rd) o.e_rs1 = wb;
      else                                 o.e_rs1 = m_regs[v.rs1];
      if (v.rst || v.rs2 == 5'd0)          o.e_rs2 = 32'd0;
      else if (BYP && we && v.rs2 == v.rd) o.e_rs2 = wb;
      else                                 o.e_rs2 = m_regs[v.rs2];
      return o;
   endfunction

   task automatic model_commit(input vec_t v);
      if (v.rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 32'd0;
      end else if (v.crt[1] && v.rd != 5'd0) begin
         m_regs[v.rd] = v.crt[0] ? v.rdata : v.alu;
         m_cnt        = m_cnt + 32'd1;
      end
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check outputs mid-cycle, then take the edge
   task automatic apply(input vec_t v, input int idx, input string tag);
      rst                  = v.rst;
      bus_if.CRT_WB_IN     = v.crt;
      bus_if.READ_DATA_IN  = v.rdata;
      bus_if.ALU_RESULT_IN = v.alu;
      bus_if.RD_IN         = v.rd;
      bus_if.RS1_ADDR      = v.rs1;
      bus_if.RS2_ADDR      = v.rs2;
      #2;
      chk({tag, ".rs1"},   idx, bus_if.RS1_DATA, v.e_rs1);
      chk({tag, ".rs2"},   idx, bus_if.RS2_DATA, v.e_rs2);
      chk({tag, ".wbdat"}, idx, bus_if.WB_DATA,  v.e_wb);
      chk({tag, ".wbwe"},  idx, {31'd0, bus_if.WB_WE}, {31'd0, v.e_we});
      chk({tag, ".wbrd"},  idx, {27'd0, bus_if.WB_RD}, {27'd0, v.e_wbrd});
      chk({tag, ".count"}, idx, bus_if.WB_COUNT, v.e_cnt);
      @(posedge clk);
      #1;
      model_commit(v);
   endtask

   initial begin
      vec_t v;

      // Directed table; bypass-dependent reads resolve through BYP
      tbl[0]  = mk(0, 2'b10, 32'h0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      tbl[1]  = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
      tbl[2]  = mk(0, 2'b11, 32'h12345678, 32'hFFFFFFFF, 5'd5, 5'd5, 5'd0,
                   BYP ? 32'h12345678 : 32'h0, 32'h0, 32'h12345678, 1'b1, 5'd5, 32'd0);
      tbl[3]  = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0,
                   32'h12345678, 32'h0, 32'h0, 1'b0, 5'd0, 32'd1);
      tbl[4]  = mk(0, 2'b10, 32'h0, 32'h11, 5'd7, 5'd0, 5'd7,
                   32'h0, BYP ? 32'h11 : 32'h0, 32'h11, 1'b1, 5'd7, 32'd1);
      tbl[5]  = mk(0, 2'b10, 32'h0, 32'h22, 5'd7, 5'd0, 5'd7,
                   32'h0, BYP ? 32'h22 : 32'h11, 32'h22, 1'b1, 5'd7, 32'd2);
      tbl[6]  = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7,
                   32'h0, 32'h22, 32'h0, 1'b0, 5'd0, 32'd3);
      tbl[7]  = mk(0, 2'b10, 32'h0, 32'hAAAA, 5'd9, 5'd9, 5'd0,
                   BYP ? 32'hAAAA : 32'h0, 32'h0, 32'hAAAA, 1'b1, 5'd9, 32'd3);
      tbl[8]  = mk(0, 2'b10, 32'h0, 32'hBBBB, 5'd9, 5'd9, 5'd0,
                   BYP ? 32'hBBBB : 32'hAAAA, 32'h0, 32'hBBBB, 1'b1, 5'd9, 32'd4);
      tbl[9]  = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9,
                   32'hBBBB, 32'hBBBB, 32'h0, 1'b0, 5'd0, 32'd5);
      tbl[10] = mk(0, 2'b10, 32'h0, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd7,
                   BYP ? 32'hA5A5A5A5 : 32'h0, 32'h22, 32'hA5A5A5A5, 1'b1, 5'd3, 32'd5);
      tbl[11] = mk(1, 2'b10, 32'h0, 32'h1, 5'd4, 5'd3, 5'd4,
                   32'h0, 32'h0, 32'h1, 1'b0, 5'd0, 32'd6);
      tbl[12] = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4,
                   32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
      tbl[13] = mk(0, 2'b01, 32'h77, 32'h0, 5'd6, 5'd6, 5'd5,
                   32'h0, 32'h0, 32'h77, 1'b0, 5'd0, 32'd0);
      tbl[14] = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd6, 5'd7,
                   32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);

      // Initial reset
      bus_if.CRT_WB_IN     = 2'b00;
      bus_if.READ_DATA_IN  = 32'h0;
      bus_if.ALU_RESULT_IN = 32'h0;
      bus_if.RD_IN         = 5'd0;
      bus_if.RS1_ADDR      = 5'd0;
      bus_if.RS2_ADDR      = 5'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      v = mk(1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
      model_commit(v);

      // Every index reads zero after reset on both ports
      for (int i = 0; i < 32; i++) begin
         v = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i),
                32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
         apply(v, i, "rst_read");
      end

      // Directed table
      for (int i = 0; i < 15; i++) begin
         apply(tbl[i], i, "tbl");
      end

      // Counter wrap: preload all-ones, one commit takes it back to zero
      force dut.r_wb_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_wb_count;
      m_cnt = 32'hFFFF_FFFF;
      v = mk(0, 2'b10, 32'h0, 32'h5, 5'd1, 5'd1, 5'd0,
             BYP ? 32'h5 : 32'h0, 32'h0, 32'h5, 1'b1, 5'd1, 32'hFFFF_FFFF);
      apply(v, 0, "wrap");
      v = mk(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0,
             32'h5, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
      apply(v, 1, "wrap");

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         v.rst   = ($urandom_range(0, 40) == 0);
         v.crt   = 2'($urandom_range(0, 3));
         v.rdata = $urandom;
         v.alu   = $urandom;
         v.rd    = 5'($urandom_range(0, 31));
         v.rs1   = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
         v.rs2   = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
         v = model_expect(v);
         apply(v, i, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_wb_regfile
`default_nettype wire
